// File: rtl/text_renderer_param.sv
`timescale 1ns/1ps
// Renders a vertical column of product-ID glyphs onto a raster with a 2-cycle pixel pipeline,
// a double-buffered ID bank committed at frame start, and a blinking inverted cursor cell.
module text_renderer_param #(
  parameter int unsigned N_SLOTS      = 12,
  parameter int unsigned ID_W         = 4,
  parameter int unsigned GLYPH_W      = 7,
  parameter int unsigned GLYPH_H      = 9,
  parameter int unsigned X0           = 16,
  parameter int unsigned Y0           = 16,
  parameter int unsigned ROW_GAP      = 3,
  parameter int unsigned BLINK_FRAMES = 32,
  localparam int unsigned CUR_W       = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_SLOTS*ID_W-1:0]   ids_in,
  input  logic                      ids_valid,
  output logic                      ids_ready,
  input  logic [9:0]                H_counter,
  input  logic [9:0]                V_counter,
  input  logic [CUR_W-1:0]          cursor_idx,
  input  logic                      cursor_en,
  output logic                      output_bit
);

  localparam int unsigned GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int unsigned SLOT_PITCH = GLYPH_H + ROW_GAP;
  localparam int unsigned ROW_W      = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int unsigned COL_W      = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned IDX_W      = (GLYPH_BITS > 1) ? $clog2(GLYPH_BITS) : 1;
  localparam int unsigned BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned BANK_W     = N_SLOTS * ID_W;

  logic [BANK_W-1:0]  pend_q, pend_d, act_q, act_d;
  logic               ready_q, ready_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               s1_in_q, s1_in_d;
  logic [CUR_W-1:0]   s1_slot_q, s1_slot_d;
  logic [ROW_W-1:0]   s1_row_q, s1_row_d;
  logic [COL_W-1:0]   s1_col_q, s1_col_d;
  logic               out_q, out_d;
  logic               frame_start_c;
  logic               hit_row_c, hit_col_c;

  // Glyph table: 7-bit rows, top row first; ID 0 and all-ones IDs are overridden.
  function automatic logic [GLYPH_BITS-1:0] glyph_rom(input logic [ID_W-1:0] id);
    logic [62:0] g;
    case (4'(id))
      4'd1:  g = {7'b0001000,7'b0011000,7'b0101000,7'b0001000,7'b0001000,7'b0001000,7'b0001000,7'b0001000,7'b0111110};
      4'd2:  g = {7'b0011100,7'b0100010,7'b0000010,7'b0000100,7'b0001000,7'b0010000,7'b0100000,7'b0100000,7'b0111110};
      4'd3:  g = {7'b0111100,7'b0000010,7'b0000010,7'b0011100,7'b0000010,7'b0000010,7'b0000010,7'b0000010,7'b0111100};
      4'd4:  g = {7'b0000100,7'b0001100,7'b0010100,7'b0100100,7'b0111110,7'b0000100,7'b0000100,7'b0000100,7'b0000100};
      4'd5:  g = {7'b0111110,7'b0100000,7'b0100000,7'b0111100,7'b0000010,7'b0000010,7'b0000010,7'b0100010,7'b0011100};
      4'd6:  g = {7'b0011100,7'b0100000,7'b0100000,7'b0111100,7'b0100010,7'b0100010,7'b0100010,7'b0100010,7'b0011100};
      4'd7:  g = {7'b0111110,7'b0000010,7'b0000100,7'b0000100,7'b0001000,7'b0001000,7'b0010000,7'b0010000,7'b0010000};
      4'd8:  g = {7'b0011100,7'b0100010,7'b0100010,7'b0011100,7'b0100010,7'b0100010,7'b0100010,7'b0100010,7'b0011100};
      4'd9:  g = {7'b0011100,7'b0100010,7'b0100010,7'b0100010,7'b0011110,7'b0000010,7'b0000010,7'b0000010,7'b0011100};
      4'd10: g = {7'b0011100,7'b0100010,7'b0100010,7'b0100010,7'b0111110,7'b0100010,7'b0100010,7'b0100010,7'b0100010};
      4'd11: g = {7'b0111100,7'b0100010,7'b0100010,7'b0111100,7'b0100010,7'b0100010,7'b0100010,7'b0100010,7'b0111100};
      4'd12: g = {7'b0011100,7'b0100010,7'b0100000,7'b0100000,7'b0100000,7'b0100000,7'b0100000,7'b0100010,7'b0011100};
      4'd13: g = {7'b0111000,7'b0100100,7'b0100010,7'b0100010,7'b0100010,7'b0100010,7'b0100010,7'b0100100,7'b0111000};
      4'd14: g = {7'b0111110,7'b0100000,7'b0100000,7'b0111100,7'b0100000,7'b0100000,7'b0100000,7'b0100000,7'b0111110};
      default: g = {7'b0111110,7'b0100010,7'b0100010,7'b0100010,7'b0100010,7'b0100010,7'b0100010,7'b0100010,7'b0111110};
    endcase
    if (id == '0)      return '0;
    else if (id == '1) return '1;
    else               return GLYPH_BITS'(g);
  endfunction

  assign frame_start_c = (H_counter == '0) && (V_counter == '0);

  // Bank handoff and blink timing; commits only at frame start so the active bank is stable per frame.
  always_comb begin
    pend_d      = pend_q;
    act_d       = act_q;
    ready_d     = ready_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (frame_start_c && !ready_q) begin
      act_d   = pend_q;
      ready_d = 1'b1;
    end
    if (ids_valid && ready_q) begin
      pend_d  = ids_in;
      ready_d = 1'b0;
    end
    if (frame_start_c) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_d     = !blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Stage 1: locate the slot cell and local row/column.
  always_comb begin
    hit_row_c = 1'b0;
    s1_slot_d = '0;
    s1_row_d  = '0;
    for (int unsigned s = 0; s < N_SLOTS; s++) begin
      if (({1'b0, V_counter} >= 11'(Y0 + s * SLOT_PITCH)) &&
          ({1'b0, V_counter} <  11'(Y0 + s * SLOT_PITCH + GLYPH_H))) begin
        hit_row_c = 1'b1;
        s1_slot_d = CUR_W'(s);
        s1_row_d  = ROW_W'({1'b0, V_counter} - 11'(Y0 + s * SLOT_PITCH));
      end
    end
    hit_col_c = ({1'b0, H_counter} >= 11'(X0)) && ({1'b0, H_counter} < 11'(X0 + GLYPH_W));
    s1_col_d  = hit_col_c ? COL_W'({1'b0, H_counter} - 11'(X0)) : '0;
    s1_in_d   = hit_row_c && hit_col_c;
  end

  // Stage 2: ROM lookup, bit select, cursor inversion.
  always_comb begin
    logic [ID_W-1:0]       id;
    logic [GLYPH_BITS-1:0] glyph;
    logic [IDX_W-1:0]      pix_idx;
    logic                  hl;
    id = '0;
    for (int unsigned s = 0; s < N_SLOTS; s++) begin
      if (s1_slot_q == CUR_W'(s)) id = act_q[(N_SLOTS - 1 - s) * ID_W +: ID_W];
    end
    glyph   = glyph_rom(id);
    pix_idx = IDX_W'((GLYPH_H - 1 - 32'(s1_row_q)) * GLYPH_W + (GLYPH_W - 1 - 32'(s1_col_q)));
    hl      = cursor_en && blink_q && (32'(cursor_idx) < N_SLOTS) && (cursor_idx == s1_slot_q);
    out_d   = s1_in_q && (glyph[pix_idx] ^ hl);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q      <= '0;
      act_q       <= '0;
      ready_q     <= 1'b1;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      s1_in_q     <= 1'b0;
      s1_slot_q   <= '0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      out_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      act_q       <= act_d;
      ready_q     <= ready_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      s1_in_q     <= s1_in_d;
      s1_slot_q   <= s1_slot_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      out_q       <= out_d;
    end
  end

  assign ids_ready  = ready_q;
  assign output_bit = out_q;

endmodule

// File: tb/tb_text_renderer_param.sv
`timescale 1ns/1ps
// Scoreboarded bench for text_renderer_param: a default build and an N_SLOTS=4/ID_W=3 build
// share one raster; expected pixels are queued at drive time and compared two cycles later.
module tb_text_renderer_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  h, v;
  logic [47:0] ids_in1;
  logic        vld1, rdy1, out1;
  logic [3:0]  cidx;
  logic        cen;
  logic [11:0] ids_in2;
  logic        vld2, rdy2, out2;
  logic [1:0]  cidx2;
  logic        cen2;

  text_renderer_param dut1 (
    .CLK(clk), .RST(rst), .ids_in(ids_in1), .ids_valid(vld1), .ids_ready(rdy1),
    .H_counter(h), .V_counter(v), .cursor_idx(cidx), .cursor_en(cen), .output_bit(out1));

  text_renderer_param #(.N_SLOTS(4), .ID_W(3)) dut2 (
    .CLK(clk), .RST(rst), .ids_in(ids_in2), .ids_valid(vld2), .ids_ready(rdy2),
    .H_counter(h), .V_counter(v), .cursor_idx(cidx2), .cursor_en(cen2), .output_bit(out2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int  m_act1[12], m_pend1[12], m_act2[4], m_pend2[4];
  bit  m_full1, m_full2, m_phase;
  int  m_cnt;
  logic [47:0] nx_ids1;
  logic        nx_vld1;
  logic [11:0] nx_ids2;
  logic        nx_vld2;

  logic  q1[$];
  logic  q2[$];
  string qt[$];

  function automatic logic mpx(input int hh, input int vv, input bit two);
    int ns, idmax, y0, id;
    logic b;
    ns    = two ? 4 : 12;
    idmax = two ? 7 : 15;
    for (int s = 0; s < ns; s++) begin
      y0 = 16 + s * 12;
      if (vv >= y0 && vv < y0 + 9 && hh >= 16 && hh < 23) begin
        id = two ? m_act2[s] : m_act1[s];
        b  = (id == idmax);
        if (!two && cen && m_phase && int'(cidx) < 12 && int'(cidx) == s) b = !b;
        return b;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [47:0] pack1(input int s, input logic [3:0] id);
    logic [47:0] r;
    r = 48'(id);
    return r << (4 * (11 - s));
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 12; s++) begin m_act1[s] = 0; m_pend1[s] = 0; end
    for (int s = 0; s < 4; s++)  begin m_act2[s] = 0; m_pend2[s] = 0; end
    m_full1 = 0; m_full2 = 0; m_cnt = 0; m_phase = 0;
  endtask

  // One raster cycle: retire the oldest queued pixel, drive a new one, advance the model.
  task automatic px(input int hh, input int vv);
    bit fs;
    string t;
    @(negedge clk);
    if (q1.size() >= 2) begin
      t = qt.pop_front();
      check({"px1", t}, out1, q1.pop_front());
      check({"px2", t}, out2, q2.pop_front());
    end
    check("ids_ready1", rdy1, !m_full1);
    check("ids_ready2", rdy2, !m_full2);
    h = 10'(hh); v = 10'(vv);
    vld1 = nx_vld1; ids_in1 = nx_ids1; nx_vld1 = 1'b0;
    vld2 = nx_vld2; ids_in2 = nx_ids2; nx_vld2 = 1'b0;
    fs = (hh == 0 && vv == 0);
    if (fs && m_full1) begin
      m_act1 = m_pend1; m_full1 = 0;
    end else if (vld1 && !m_full1) begin
      for (int s = 0; s < 12; s++) m_pend1[s] = int'(ids_in1[(11 - s) * 4 +: 4]);
      m_full1 = 1;
    end
    if (fs && m_full2) begin
      m_act2 = m_pend2; m_full2 = 0;
    end else if (vld2 && !m_full2) begin
      for (int s = 0; s < 4; s++) m_pend2[s] = int'(ids_in2[(3 - s) * 3 +: 3]);
      m_full2 = 1;
    end
    if (fs) begin
      if (m_cnt == 31) begin m_cnt = 0; m_phase = !m_phase; end
      else m_cnt++;
    end
    q1.push_back(mpx(hh, vv, 1'b0));
    q2.push_back(mpx(hh, vv, 1'b1));
    qt.push_back($sformatf("(%0d,%0d)", hh, vv));
  endtask

  task automatic flush();
    px(0, 1);
    px(0, 1);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      px(0, 0);
      px(5, 5);
    end
  endtask

  task automatic do_reset();
    flush();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_out1", out1, 1'b0);
    check("rst_out2", out2, 1'b0);
    check("rst_ready1", rdy1, 1'b1);
    check("rst_ready2", rdy2, 1'b1);
    rst = 1'b0;
  endtask

  int hs[4] = '{15, 16, 22, 23};

  initial begin
    rst = 1'b1; h = 10'd0; v = 10'd1;
    ids_in1 = '0; vld1 = 1'b0; cidx = '0; cen = 1'b0;
    ids_in2 = '0; vld2 = 1'b0; cidx2 = '0; cen2 = 1'b0;
    nx_ids1 = '0; nx_vld1 = 1'b0; nx_ids2 = '0; nx_vld2 = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out1", out1, 1'b0);
    check("rst_ready1", rdy1, 1'b1);
    check("rst_ready2", rdy2, 1'b1);
    rst = 1'b0;

    // Blank frame after reset
    px(0, 0);
    for (int vv = 0; vv <= 160; vv++)
      for (int i = 0; i < 4; i++) px(hs[i], vv);

    // Mid-frame transfer stays invisible until the next frame start
    nx_ids1 = pack1(0, 4'hF); nx_vld1 = 1'b1;
    nx_ids2 = 12'h007;        nx_vld2 = 1'b1;
    px(100, 50);
    px(16, 16);
    px(22, 24);
    px(0, 0);
    px(16, 16); px(23, 16); px(16, 25); px(22, 24); px(15, 16); px(16, 15); px(19, 20);
    for (int vv = 48; vv <= 64; vv++)
      for (int hh = 14; hh <= 24; hh += 2) px(hh, vv);
    px(16, 52); px(22, 60); px(16, 61); px(16, 51);

    // Second offer while not ready is dropped
    nx_ids1 = pack1(2, 4'hF); nx_vld1 = 1'b1;
    px(200, 100);
    nx_ids1 = 48'hFFFF_FFFF_FFFF; nx_vld1 = 1'b1;
    px(201, 100);
    px(16, 40);
    px(0, 0);
    px(16, 40); px(22, 48); px(16, 16); px(16, 64); px(16, 100);

    // Transfer coinciding with frame start is held until the following frame start
    nx_ids1 = pack1(5, 4'hF); nx_vld1 = 1'b1;
    px(0, 0);
    px(16, 76); px(16, 40);
    px(0, 0);
    px(16, 76); px(22, 84); px(16, 40);

    // Reset mid-frame discards a pending transfer
    nx_ids1 = pack1(0, 4'hF); nx_vld1 = 1'b1;
    px(300, 200);
    do_reset();
    px(0, 0);
    px(16, 16); px(16, 76); px(22, 24);

    // Cursor blink on a blank slot
    do_reset();
    cidx = 4'd1; cen = 1'b1;
    frames(31);
    px(16, 28);
    frames(1);
    px(16, 28); px(16, 27); px(22, 36); px(16, 37); px(16, 16); px(23, 28); px(19, 32);
    frames(32);
    px(16, 28); px(22, 36);

    // Out-of-range cursor index and cursor disable
    frames(32);
    px(16, 28);
    flush();
    cidx = 4'd13;
    for (int s = 0; s < 12; s++) begin
      px(16, 16 + 12 * s);
      px(22, 24 + 12 * s);
    end
    flush();
    cidx = 4'd1; cen = 1'b0;
    px(16, 28); px(19, 32);
    flush();
    cidx = 4'd11; cen = 1'b1;
    px(16, 148); px(22, 156); px(16, 157);
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
